// File: rtl/qr_input_feeder.sv
// Frame row buffer feeding QR_top: loads up to DEPTH rows from the host, streams them out on
// qr_value, holds the last row until finish_in, then re-arms.
module qr_input_feeder #(
  parameter int unsigned DW    = 13,
  parameter int unsigned DEPTH = 9,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_last,
  input  logic [DW-1:0] wr_a,
  input  logic [DW-1:0] wr_b,
  input  logic [DW-1:0] wr_c,
  input  logic [DW-1:0] wr_d,
  output logic          wr_ready,
  input  logic          qr_value,
  input  logic          finish_in,
  output logic [DW-1:0] data_inA,
  output logic [DW-1:0] data_inB,
  output logic [DW-1:0] data_inC,
  output logic [DW-1:0] data_inD,
  output logic          last_end,
  output logic          busy,
  output logic          ovf_err
);

  localparam int unsigned RW = 4 * DW + 1;

  typedef enum logic [1:0] {StLoad, StStream, StHold} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] count_q, count_d;
  logic [RW-1:0] out_q, out_d;
  logic          ovf_q;

  // Row layout: {last, a, b, c, d}
  logic [RW-1:0] mem [DEPTH];

  logic          accept;
  logic          last_acc;
  logic [RW-1:0] rd_row;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready = (state_q == StLoad) && (count_q != AW'(DEPTH));
  assign accept   = wr_en & wr_ready;
  // A full buffer closes the frame even without wr_last.
  assign last_acc = wr_last | (count_q == AW'(DEPTH - 1));
  assign rd_row   = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= {last_acc, wr_a, wr_b, wr_c, wr_d};
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = '0;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = count_q + 1'b1;
          if (last_acc) state_d = StStream;
        end
      end
      StStream: begin
        if (finish_in) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          state_d  = StLoad;
        end else if (qr_value && (count_q != '0)) begin
          out_d    = rd_row;
          rd_ptr_d = ptr_inc(rd_ptr_q);
          count_d  = count_q - 1'b1;
          if (rd_row[RW-1]) state_d = StHold;
        end
      end
      StHold: begin
        out_d = out_q;
        if (finish_in) begin
          out_d    = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          state_d  = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StLoad;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      ovf_q    <= ovf_q | (wr_en & ~wr_ready);
    end
  end

  assign last_end = out_q[RW-1];
  assign data_inA = out_q[4*DW-1:3*DW];
  assign data_inB = out_q[3*DW-1:2*DW];
  assign data_inC = out_q[2*DW-1:DW];
  assign data_inD = out_q[DW-1:0];
  assign busy     = (state_q != StLoad);
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_qr_input_feeder.sv
// Bench for qr_input_feeder: frames are queued in a reference model and every output cycle is
// checked against the rows expected from that queue.
module tb_qr_input_feeder;

  localparam int unsigned DW    = 13;
  localparam int unsigned DEPTH = 9;
  localparam int unsigned AW    = 4;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
  } row_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_last = 1'b0;
  logic [DW-1:0] wr_a = '0, wr_b = '0, wr_c = '0, wr_d = '0;
  logic          wr_ready;
  logic          qr_value = 1'b0;
  logic          finish_in = 1'b0;
  logic [DW-1:0] data_inA, data_inB, data_inC, data_inD;
  logic          last_end, busy, ovf_err;

  qr_input_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_last(wr_last),
    .wr_a(wr_a), .wr_b(wr_b), .wr_c(wr_c), .wr_d(wr_d), .wr_ready(wr_ready),
    .qr_value(qr_value), .finish_in(finish_in),
    .data_inA(data_inA), .data_inB(data_inB), .data_inC(data_inC), .data_inD(data_inD),
    .last_end(last_end), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  row_t frame_q[$];
  row_t hold_row;
  bit   held = 0;
  int   wcount = 0;
  bit   exp_ovf = 0;

  function automatic row_t observed();
    return {last_end, data_inA, data_inB, data_inC, data_inD};
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  task automatic clear_model();
    frame_q.delete();
    held   = 0;
    wcount = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    tests++;
    if ({observed(), busy, wr_ready, ovf_err} !== {53'd0, 3'b010}) begin
      fails++;
      $display("FAIL reset_state: got out=%h busy=%b rdy=%b ovf=%b, want all 0 with rdy=1",
               observed(), busy, wr_ready, ovf_err);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_ovf = 0;
    clear_model();
  endtask

  task automatic write_row(input bit last, input logic [DW-1:0] a, b, c, d);
    row_t r;
    @(negedge clk);
    wr_en = 1'b1; wr_last = last;
    wr_a = a; wr_b = b; wr_c = c; wr_d = d;
    qr_value = 1'b0; finish_in = 1'b0;
    #1;
    tests++;
    if (wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL write_ready row %0d: got %b want 1", wcount, wr_ready);
    end
    @(posedge clk);
    r.last = last | (wcount == DEPTH - 1);
    r.a = a; r.b = b; r.c = c; r.d = d;
    frame_q.push_back(r);
    wcount++;
  endtask

  task automatic write_frame(input int n, input bit use_last, input bit ramp);
    for (int i = 0; i < n; i++) begin
      if (ramp)
        write_row(use_last && (i == n - 1), DW'(i + 1), DW'(-(i + 1)), DW'(2 * (i + 1)),
                  DW'(-2 * (i + 1)));
      else
        write_row(use_last && (i == n - 1), rnd(), rnd(), rnd(), rnd());
    end
  endtask

  // mode 0: qr_value held 1, 1: toggled 1,0,1,0, 2: random. max_pops=0 runs into HOLD.
  task automatic stream(input int mode, input int max_pops, input bit poke_ovf);
    row_t exp;
    bit   qrv;
    int   pops = 0;
    int   hold_cycles = 0;
    bit   done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      wr_en = poke_ovf && (cyc == 0);
      wr_last = $urandom_range(0, 1);
      wr_a = rnd(); wr_b = rnd(); wr_c = rnd(); wr_d = rnd();
      finish_in = 1'b0;
      qrv = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      qr_value = qrv;
      @(posedge clk);
      #1;
      if (poke_ovf && cyc == 0) exp_ovf = 1;
      if (held) begin
        exp = hold_row;
        hold_cycles++;
      end else if (qrv && frame_q.size() > 0) begin
        exp = frame_q.pop_front();
        pops++;
        if (exp.last) begin
          held = 1;
          hold_row = exp;
        end
      end else begin
        exp = '0;
      end
      tests++;
      if ({observed(), busy, wr_ready, ovf_err} !== {exp, 1'b1, 1'b0, exp_ovf}) begin
        fails++;
        $display("FAIL stream cyc %0d: got out=%h busy=%b rdy=%b ovf=%b want out=%h 1 0 %b",
                 cyc, observed(), busy, wr_ready, ovf_err, exp, exp_ovf);
      end
      if ((held && hold_cycles >= 3) || (max_pops != 0 && pops == max_pops)) done = 1;
    end
    wr_en = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL stream_timeout: got pops=%0d, required frame end within 200 cycles", pops);
    end
  endtask

  task automatic finish_frame(input bit qrv);
    @(negedge clk);
    wr_en = 1'b0; finish_in = 1'b1; qr_value = qrv;
    @(posedge clk);
    #1;
    tests++;
    if ({observed(), busy, wr_ready} !== {53'd0, 2'b01}) begin
      fails++;
      $display("FAIL finish: got out=%h busy=%b rdy=%b want out=0 busy=0 rdy=1",
               observed(), busy, wr_ready);
    end
    @(negedge clk);
    finish_in = 1'b0; qr_value = 1'b0;
    clear_model();
  endtask

  task automatic test_full_frame();
    write_frame(9, 1, 1);
    stream(0, 0, 0);
    finish_frame(0);
  endtask

  task automatic test_gapped();
    write_frame(9, 1, 1);
    stream(1, 0, 0);
    finish_frame(1);
  endtask

  task automatic test_short_frame();
    write_frame(3, 1, 0);
    stream(2, 0, 0);
    finish_frame(0);
  endtask

  task automatic test_full_no_last();
    write_frame(9, 0, 0);
    stream(0, 0, 1);
    finish_frame(0);
  endtask

  task automatic test_abort();
    write_frame(9, 1, 0);
    stream(0, 4, 0);
    finish_frame(1);
    write_frame(2, 1, 0);
    stream(0, 0, 0);
    finish_frame(0);
  endtask

  task automatic test_async_reset();
    write_frame(6, 1, 0);
    stream(0, 2, 1);
    #3;
    reset = 1'b0;
    #1;
    tests++;
    if ({observed(), busy, wr_ready, ovf_err} !== {53'd0, 3'b010}) begin
      fails++;
      $display("FAIL async_reset: got out=%h busy=%b rdy=%b ovf=%b want 0 0 1 0",
               observed(), busy, wr_ready, ovf_err);
    end
    @(negedge clk);
    reset = 1'b1;
    qr_value = 1'b0;
    exp_ovf = 0;
    clear_model();
  endtask

  task automatic test_random_frames();
    int n;
    bit ul;
    for (int f = 0; f < 8; f++) begin
      n  = $urandom_range(1, DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      write_frame(n, ul, 0);
      stream(2, 0, 0);
      finish_frame(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gapped();
    test_short_frame();
    test_full_no_last();
    test_abort();
    test_async_reset();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
